// File: rtl/spram8_ldr.sv
// spram8_ldr: command-driven byte loader/dumper in front of an 8-bit SPRAM.
// LOAD streams bytes from s_* into memory at 1 byte/clk. DUMP reads a range
// back out through a 2-entry buffer that absorbs the one-cycle read latency
// and downstream backpressure.
// Optional feature: define EFORTH1_LDR_CKSUM_EN to get an 8-bit wrapping
// checksum of bytes written/popped; otherwise cksum is tied to zero.
`default_nettype none

module spram8_ldr #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  // command channel
  input  logic          cmd_vld,
  output logic          cmd_rdy,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  // input byte stream (LOAD)
  input  logic          s_vld,
  output logic          s_rdy,
  input  logic [7:0]    s_dat,
  // output byte stream (DUMP)
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [7:0]    o_dat,
  // SPRAM port
  output logic          m_we,
  output logic [AW-1:0] m_ai,
  output logic [7:0]    m_vi,
  input  logic [7:0]    m_vo,
  // status
  output logic          busy,
  output logic          done,
  output logic [7:0]    cksum
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DUMP,
    ST_FIN
  } state_e;

  localparam logic [AW-1:0] ONE = AW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [AW-1:0] cnt_q,   cnt_d;
  logic          inflight_q, inflight_d;
  logic [1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [7:0]    fifo_q [2];
  logic          wr_ptr_q, rd_ptr_q;

  logic          ld_hs;
  logic          rd_iss;
  logic          push;
  logic          pop;
  logic [1:0]    occ;

  // Handshake decode and read-issue throttle.
  always_comb begin
    ld_hs  = (state_q == ST_LOAD) && s_vld;
    o_vld  = (state_q == ST_DUMP) && (fifo_cnt_q != 2'd0);
    pop    = o_vld && o_rdy;
    push   = inflight_q;
    // A pop this cycle frees a slot before the new read's data lands two
    // edges later, so it is credited here; that keeps 1 byte/clk streaming
    // with o_rdy high while never holding more than 2 bytes.
    occ    = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    rd_iss = (state_q == ST_DUMP) && (cnt_q != '0) && (occ < 2'd2);
  end

  // Next-state logic for the command FSM and address/count tracking.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    inflight_d = rd_iss;
    fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_vld) begin
          addr_d = cmd_addr;
          cnt_d  = cmd_len;
          if (cmd_len == '0) state_d = ST_FIN;
          else if (cmd_wr)   state_d = ST_LOAD;
          else               state_d = ST_DUMP;
        end
      end
      ST_LOAD: begin
        if (s_vld) begin
          addr_d = addr_q + ONE;
          cnt_d  = cnt_q - ONE;
          if (cnt_q == ONE) state_d = ST_FIN;
        end
      end
      ST_DUMP: begin
        if (rd_iss) begin
          addr_d = addr_q + ONE;
          cnt_d  = cnt_q - ONE;
        end
        // Leave on the edge that pops the final byte so done follows it directly.
        if ((cnt_d == '0) && !rd_iss && (fifo_cnt_d == 2'd0)) state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together from pre-edge values.
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Two-entry output buffer: capture read data one cycle after issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the buffer storage is reset because o_dat must read 0 out of
      // reset; larger memories would normally be left unreset.
      fifo_q[0] <= 8'h00;
      fifo_q[1] <= 8'h00;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
    end else begin
      if (push) fifo_q[wr_ptr_q] <= m_vo;
      wr_ptr_q <= wr_ptr_q ^ push;
      rd_ptr_q <= rd_ptr_q ^ pop;
    end
  end

  // Output decode.
  always_comb begin
    cmd_rdy = (state_q == ST_IDLE);
    s_rdy   = (state_q == ST_LOAD);
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_FIN);
    m_we    = ld_hs;
    m_ai    = addr_q;
    m_vi    = (state_q == ST_LOAD) ? s_dat : 8'h00;
    o_dat   = fifo_q[rd_ptr_q];
  end

`ifdef EFORTH1_LDR_CKSUM_EN
  logic [7:0] cksum_q, cksum_d;

  // Running checksum over bytes written or popped in the current command.
  always_comb begin
    cksum_d = cksum_q;
    if ((state_q == ST_IDLE) && cmd_vld) cksum_d = 8'h00;
    else if (ld_hs)                      cksum_d = cksum_q + s_dat;
    else if (pop)                        cksum_d = cksum_q + o_dat;
  end

  // Checksum register; holds after done until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cksum_q <= 8'h00;
    else        cksum_q <= cksum_d;
  end

  assign cksum = cksum_q;
`else
  assign cksum = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spram8_ldr.sv
// Self-checking bench for spram8_ldr: directed and randomized LOAD/DUMP
// commands checked against a byte-array reference memory kept in the bench.
`timescale 1ns/1ps

module tb_spram8_ldr;

  localparam int AW = 17;

  logic          clk;
  logic          rst_n;
  logic          cmd_vld;
  logic          cmd_rdy;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic          s_vld;
  logic          s_rdy;
  logic [7:0]    s_dat;
  logic          o_vld;
  logic          o_rdy;
  logic [7:0]    o_dat;
  logic          m_we;
  logic [AW-1:0] m_ai;
  logic [7:0]    m_vi;
  logic [7:0]    m_vo;
  logic          busy;
  logic          done;
  logic [7:0]    cksum;

  int n_vec = 0;
  int n_err = 0;

  // Reference memory contents, as the bench intends them to be.
  logic [7:0] ref_mem [int];

  spram8_ldr #(.AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_vld  (cmd_vld),
    .cmd_rdy  (cmd_rdy),
    .cmd_wr   (cmd_wr),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .s_vld    (s_vld),
    .s_rdy    (s_rdy),
    .s_dat    (s_dat),
    .o_vld    (o_vld),
    .o_rdy    (o_rdy),
    .o_dat    (o_dat),
    .m_we     (m_we),
    .m_ai     (m_ai),
    .m_vi     (m_vi),
    .m_vo     (m_vo),
    .busy     (busy),
    .done     (done),
    .cksum    (cksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPRAM behavioural model: synchronous write, registered read data.
  logic [7:0] spram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (m_we) spram[m_ai] <= m_vi;
    m_vo <= spram[m_ai];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_ck(input logic [7:0] s);
`ifdef EFORTH1_LDR_CKSUM_EN
    return s;
`else
    return 8'h00;
`endif
  endfunction

  // Random command traffic while busy; it must never be accepted.
  task automatic noise();
    cmd_vld  = 1'($urandom_range(0, 1));
    cmd_wr   = 1'($urandom_range(0, 1));
    cmd_addr = AW'($urandom);
    cmd_len  = AW'($urandom);
  endtask

  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] len);
    @(negedge clk);
    cmd_vld  = 1'b1;
    cmd_wr   = wr;
    cmd_addr = a;
    cmd_len  = len;
    s_vld    = 1'b0;
    o_rdy    = 1'b0;
    #1;
    check("cmd_rdy_idle", cmd_rdy, 1);
    check("busy_idle", busy, 0);
  endtask

  task automatic idle_after(input logic [7:0] ck);
    @(negedge clk);
    cmd_vld = 1'b0;
    s_vld   = 1'b0;
    o_rdy   = 1'b0;
    #1;
    check("cmd_rdy_after_done", cmd_rdy, 1);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("cksum_hold", cksum, exp_ck(ck));
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [7:0] q[$], input bit gaps);
    int            len;
    int            idx;
    int            cyc;
    logic [AW-1:0] ea;
    logic [7:0]    sum;
    len = q.size();
    idx = 0;
    cyc = 0;
    ea  = a;
    sum = 8'h00;
    send_cmd(1'b1, a, AW'(len));
    while (idx < len && cyc < 1000) begin
      @(negedge clk);
      noise();
      s_vld = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_dat = s_vld ? q[idx] : 8'($urandom);
      #1;
      check("busy_load", busy, 1);
      check("cmd_rdy_busy", cmd_rdy, 0);
      check("s_rdy_load", s_rdy, 1);
      check("done_early_load", done, 0);
      check("m_we_load", m_we, s_vld);
      check("m_ai_load", m_ai, ea);
      if (s_vld) begin
        check("m_vi_load", m_vi, q[idx]);
        ref_mem[int'(ea)] = q[idx];
        sum = sum + q[idx];
        ea  = ea + AW'(1);
        idx++;
      end
      cyc++;
    end
    check("load_bytes_taken", idx, len);
    @(negedge clk);
    noise();
    s_vld = 1'b1;
    #1;
    check("done_load", done, 1);
    check("m_we_fin", m_we, 0);
    check("s_rdy_fin", s_rdy, 0);
    check("cksum_load", cksum, exp_ck(sum));
    idle_after(sum);
  endtask

  // mode 0: o_rdy held high; 1: o_rdy pattern 1,0,0,1,1,0,...; 2: random.
  task automatic do_dump(input logic [AW-1:0] a, input int len, input int mode);
    logic [7:0]    expq[$];
    logic [AW-1:0] ea;
    logic [7:0]    sum;
    int            idx;
    int            cyc;
    bit            last;
    bit            seen_done;
    bit            pat [6];
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    ea   = a;
    for (int i = 0; i < len; i++) begin
      expq.push_back(ref_mem.exists(int'(ea)) ? ref_mem[int'(ea)] : 8'h00);
      ea = ea + AW'(1);
    end
    sum       = 8'h00;
    idx       = 0;
    cyc       = 0;
    last      = 1'b0;
    seen_done = 1'b0;
    send_cmd(1'b0, a, AW'(len));
    while (cyc < 400) begin
      @(negedge clk);
      noise();
      case (mode)
        0:       o_rdy = 1'b1;
        1:       o_rdy = pat[cyc % 6];
        default: o_rdy = 1'($urandom_range(0, 1));
      endcase
      #1;
      check("done_dump", done, last);
      if (last) begin
        seen_done = 1'b1;
        check("o_vld_fin", o_vld, 0);
        check("cksum_dump", cksum, exp_ck(sum));
        break;
      end
      check("busy_dump", busy, 1);
      check("cmd_rdy_busy", cmd_rdy, 0);
      check("m_we_dump", m_we, 0);
      check("s_rdy_dump", s_rdy, 0);
      if (mode == 0) check("o_vld_stream", o_vld, (cyc >= 2 && cyc <= len + 1));
      else if (cyc < 2) check("o_vld_latency", o_vld, 0);
      if (o_vld && idx < len) begin
        check("o_dat", o_dat, expq[idx]);
        if (o_rdy) begin
          sum = sum + expq[idx];
          idx++;
          if (idx == len) last = 1'b1;
        end
      end
      cyc++;
    end
    check("dump_done_seen", seen_done, 1);
    idle_after(sum);
  endtask

  task automatic zero_len(input logic wr);
    send_cmd(wr, AW'($urandom), '0);
    @(negedge clk);
    cmd_vld = 1'b0;
    s_vld   = 1'b1;
    o_rdy   = 1'b1;
    #1;
    check("zl_done", done, 1);
    check("zl_m_we", m_we, 0);
    check("zl_o_vld", o_vld, 0);
    check("zl_s_rdy", s_rdy, 0);
    check("zl_busy", busy, 1);
    idle_after(8'h00);
  endtask

  task automatic check_reset_values();
    check("rst_cmd_rdy", cmd_rdy, 1);
    check("rst_s_rdy", s_rdy, 0);
    check("rst_o_vld", o_vld, 0);
    check("rst_o_dat", o_dat, 0);
    check("rst_m_we", m_we, 0);
    check("rst_m_ai", m_ai, 0);
    check("rst_m_vi", m_vi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cksum", cksum, 0);
  endtask

  function automatic void rand_bytes(output logic [7:0] q[$], input int n);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endfunction

  initial begin
    logic [7:0]    q[$];
    logic [AW-1:0] a;
    int            n;

    rst_n    = 1'b0;
    cmd_vld  = 1'b0;
    cmd_wr   = 1'b0;
    cmd_addr = '0;
    cmd_len  = '0;
    s_vld    = 1'b0;
    s_dat    = 8'h00;
    o_rdy    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed LOAD/DUMP of 11 22 33 44 at 0x100.
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_load(AW'('h00100), q, 1'b0);
    do_dump(AW'('h00100), 4, 0);

    // Backpressured DUMP with the 1,0,0,1,1,0 o_rdy pattern.
    rand_bytes(q, 6);
    do_load(AW'('h00200), q, 1'b0);
    do_dump(AW'('h00200), 6, 1);

    // Address wrap at the top of memory.
    rand_bytes(q, 4);
    do_load(AW'('h1FFFE), q, 1'b0);
    do_dump(AW'('h1FFFE), 4, 2);

    // Zero-length commands.
    zero_len(1'b1);
    zero_len(1'b0);

    // Randomized commands with input gaps and random backpressure.
    for (int k = 0; k < 8; k++) begin
      a = (k % 3 == 0) ? AW'((1 << AW) - $urandom_range(1, 6)) : AW'($urandom);
      n = $urandom_range(1, 12);
      rand_bytes(q, n);
      do_load(a, q, 1'b1);
      do_dump(a, n, (k % 2 == 0) ? 2 : 0);
    end

    // Reset during a DUMP with 3 bytes still pending.
    send_cmd(1'b0, AW'('h00200), AW'(5));
    @(negedge clk);
    cmd_vld = 1'b0;
    o_rdy   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_cmd_rdy", cmd_rdy, 1);
      check("post_rst_done", done, 0);
      check("post_rst_o_vld", o_vld, 0);
    end

    // Recovery after reset.
    rand_bytes(q, 3);
    do_load(AW'('h00400), q, 1'b0);
    do_dump(AW'('h00400), 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
